tmu_cordic_arb: RTL and testbench
=================================

Name: tmu_cordic_arb

Overview:
Arbiter and sequencer that shares one CORDIC engine between two requesters: the APB host path (h_*) and the PID loop (p_*). It accepts one request at a time with round-robin fairness and drives the engine with a start/done handshake. It returns the result to the winning requester and flags engine timeouts. It sits between the APB register bridge / PID controller and the CORDIC core, clocked from PCLK.

Parameters:
DW, 12, argument/result width
TIMEOUT, 64, max WAIT cycles before abort (>=2)
CNT_W, 7, timer width, must satisfy 2^CNT_W > TIMEOUT

Ports:
PCLK  in  1  clock, all logic rising-edge
PRESETn  in  1  reset, asynchronous assert, active-low
h_req  in  1  host request, level, held until h_ack
h_arg  in  DW  host argument, valid while h_req=1
h_ack  out  1  one-cycle pulse: host request accepted
h_done  out  1  one-cycle pulse: host result valid on res
p_req  in  1  PID request, level, held until p_ack
p_arg  in  DW  PID argument
p_ack  out  1  one-cycle pulse: PID request accepted
p_done  out  1  one-cycle pulse: PID result valid on res
res  out  DW  result register, shared by both requesters
eng_start  out  1  one-cycle engine start pulse
eng_arg  out  DW  registered engine argument
eng_done  in  1  engine completion pulse
eng_res  in  DW  engine result, valid with eng_done
owner  out  1  0=host, 1=PID; current or last grantee
timeout_err  out  1  sticky timeout flag
clr_err  in  1  clears timeout_err

Behaviour:
- Reset (async, PRESETn=0): state=IDLE; all outputs 0; timer=0; last-served pointer=PID, so host wins the first tie.
- FSM states: IDLE, START, WAIT, RESP. All outputs are Moore/registered.
- IDLE, only one req high: grant that requester.
- IDLE, both req high: grant the requester not served last (round-robin).
- IDLE, on grant: latch arg into eng_arg, set owner, go START. With no request, stay in IDLE.
- START (1 cycle): eng_start=1; ack of the owner=1; timer cleared; go WAIT.
- WAIT: timer increments each cycle. eng_done is sampled only in WAIT and ignored in all other states.
- WAIT, eng_done=1: res<=eng_res; go RESP.
- WAIT, timer reaches TIMEOUT-1 without eng_done: timeout_err<=1; res<=0; go RESP.
- WAIT, eng_done in the same cycle as the terminal count: done wins; no error.
- RESP (1 cycle): done of the owner=1; last-served pointer<=owner; go IDLE.
- res holds its value until the next capture. owner holds until the next grant.
- Requester rule: req must drop in the cycle after ack. A req still high when IDLE is re-entered counts as a new request.
- Minimum transaction: 4 cycles with engine latency 1 (IDLE, START, WAIT, RESP). Back-to-back grants have no extra bubble.
- timeout_err: set has priority over clr_err in the same cycle. Otherwise clr_err=1 clears it next edge.
- Reset mid-transaction: immediate return to IDLE. No done pulse for the aborted request. A late eng_done after reset is ignored.
- Arguments and results are passed unmodified, DW bits, no arithmetic.

Test Plan:
1. Assert reset with random inputs -> all outputs 0, owner=0, state IDLE; hold 10 cycles with no req -> eng_start never pulses.
2. Single host transaction: h_req=1, h_arg=0x123 at cycle 0; engine returns eng_done with eng_res=0x456 in the 3rd WAIT cycle (cycle 4) -> h_ack and eng_start at cycle 1, eng_arg=0x123; h_done at cycle 5 with res=0x456; p_ack/p_done stay 0.
3. Fairness: h_req and p_req high together after reset, args 0x0AA/0x055, engine latency 1 -> host served first (h_ack cycle 1), PID next (p_ack cycle 5, eng_arg=0x055); third simultaneous pair -> host granted again.
4. Timeout with TIMEOUT=64 and no eng_done -> after 64 WAIT cycles, done of owner pulses with res=0 and timeout_err=1; clr_err pulse -> timeout_err=0 next cycle; clr_err coincident with a new timeout -> timeout_err stays 1.
5. eng_done coincident with terminal count, eng_res=0xFFF -> res=0xFFF, timeout_err stays 0.
6. Reset during WAIT, then stray eng_done 2 cycles after release -> no h_done/p_done, res=0; next h_req is serviced normally.

Source files
------------

// File: rtl/tmu_cordic_arb_if.sv
// ----------------------------------------------------------------------------
// tmu_cordic_arb_if
//   Bundles the requester-side (host h_*, PID p_*) and engine-side (eng_*)
//   signals of tmu_cordic_arb so the arbiter and its neighbours connect
//   through one port.
//
//   Modports:
//     slave  - the arbiter: takes requests/engine results, drives acks,
//              done pulses, shared result, engine start/argument, status.
//     master - the environment: drives requests, arguments, engine
//              completion and clr_err; observes everything else.
// ----------------------------------------------------------------------------
interface tmu_cordic_arb_if #(
    parameter int unsigned DW = 12
);
    // host requester
    logic          h_req;
    logic [DW-1:0] h_arg;
    logic          h_ack;
    logic          h_done;
    // PID requester
    logic          p_req;
    logic [DW-1:0] p_arg;
    logic          p_ack;
    logic          p_done;
    // shared result and status
    logic [DW-1:0] res;
    logic          owner;
    logic          timeout_err;
    logic          clr_err;
    // CORDIC engine
    logic          eng_start;
    logic [DW-1:0] eng_arg;
    logic          eng_done;
    logic [DW-1:0] eng_res;

    modport slave (
        input  h_req, h_arg, p_req, p_arg, eng_done, eng_res, clr_err,
        output h_ack, h_done, p_ack, p_done, res, eng_start, eng_arg,
               owner, timeout_err
    );

    modport master (
        output h_req, h_arg, p_req, p_arg, eng_done, eng_res, clr_err,
        input  h_ack, h_done, p_ack, p_done, res, eng_start, eng_arg,
               owner, timeout_err
    );
endinterface

// File: rtl/tmu_cordic_arb.sv
// ----------------------------------------------------------------------------
// tmu_cordic_arb
//   Shares one CORDIC engine between the APB host path and the PID loop.
//   One request is accepted at a time with round-robin fairness; the engine
//   is driven with a start/done handshake, the result is returned on the
//   shared res register, and a missing engine completion is aborted after
//   TIMEOUT WAIT cycles and flagged on the sticky timeout_err.
//
//   Ports:
//     PCLK     - clock, all logic on the rising edge
//     PRESETn  - asynchronous active-low reset
//     bus      - tmu_cordic_arb_if.slave: h_*/p_* request/ack/done,
//                res, owner, timeout_err/clr_err, eng_* engine handshake
//
//   Every output is a flop; a transaction is IDLE -> START -> WAIT.. -> RESP.
// ----------------------------------------------------------------------------
module tmu_cordic_arb #(
    parameter int unsigned DW      = 12,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    tmu_cordic_arb_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             last_q, last_d;        // last served: 0=host, 1=PID
    logic             owner_q, owner_d;
    logic [DW-1:0]    eng_arg_q, eng_arg_d;
    logic [DW-1:0]    res_q, res_d;
    logic             eng_start_q, eng_start_d;
    logic             h_ack_q, h_ack_d;
    logic             p_ack_q, p_ack_d;
    logic             h_done_q, h_done_d;
    logic             p_done_q, p_done_d;
    logic             timeout_err_q, timeout_err_d;
    logic             timeout_set;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        last_d      = last_q;
        owner_d     = owner_q;
        eng_arg_d   = eng_arg_q;
        res_d       = res_q;
        eng_start_d = 1'b0;
        h_ack_d     = 1'b0;
        p_ack_d     = 1'b0;
        h_done_d    = 1'b0;
        p_done_d    = 1'b0;
        timeout_set = 1'b0;

        case (state_q)
            IDLE: begin
                // Host wins when alone, or on a tie if PID was served last.
                if (bus.h_req && (!bus.p_req || last_q)) begin
                    owner_d     = 1'b0;
                    eng_arg_d   = bus.h_arg;
                    state_d     = START;
                    eng_start_d = 1'b1;
                    h_ack_d     = 1'b1;
                end else if (bus.p_req) begin
                    owner_d     = 1'b1;
                    eng_arg_d   = bus.p_arg;
                    state_d     = START;
                    eng_start_d = 1'b1;
                    p_ack_d     = 1'b1;
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Completion is checked before the terminal count so a done
                // arriving on the last allowed cycle is still accepted.
                if (bus.eng_done) begin
                    res_d    = bus.eng_res;
                    state_d  = RESP;
                    h_done_d = ~owner_q;
                    p_done_d = owner_q;
                end else if (timer_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout_set = 1'b1;
                    res_d       = '0;
                    state_d     = RESP;
                    h_done_d    = ~owner_q;
                    p_done_d    = owner_q;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (timeout_set) begin
            timeout_err_d = 1'b1;
        end else if (bus.clr_err) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            last_q        <= 1'b1;
            owner_q       <= 1'b0;
            eng_arg_q     <= '0;
            res_q         <= '0;
            eng_start_q   <= 1'b0;
            h_ack_q       <= 1'b0;
            p_ack_q       <= 1'b0;
            h_done_q      <= 1'b0;
            p_done_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            last_q        <= last_d;
            owner_q       <= owner_d;
            eng_arg_q     <= eng_arg_d;
            res_q         <= res_d;
            eng_start_q   <= eng_start_d;
            h_ack_q       <= h_ack_d;
            p_ack_q       <= p_ack_d;
            h_done_q      <= h_done_d;
            p_done_q      <= p_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.h_ack       = h_ack_q;
    assign bus.p_ack       = p_ack_q;
    assign bus.h_done      = h_done_q;
    assign bus.p_done      = p_done_q;
    assign bus.res         = res_q;
    assign bus.eng_start   = eng_start_q;
    assign bus.eng_arg     = eng_arg_q;
    assign bus.owner       = owner_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_tmu_cordic_arb.sv
// ----------------------------------------------------------------------------
// tb_tmu_cordic_arb
//   Directed bench for tmu_cordic_arb. "Cycle N" is the clock period that
//   starts at the N-th rising edge after the stimulus cycle 0; inputs are
//   driven and outputs sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_tmu_cordic_arb;

    localparam int unsigned DW = 12;

    logic PCLK;
    logic PRESETn;
    int   total;
    int   bad;

    tmu_cordic_arb_if #(.DW(DW)) bus ();

    tmu_cordic_arb #(
        .DW      (DW),
        .TIMEOUT (64),
        .CNT_W   (7)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.h_req    = 1'b0;
        bus.h_arg    = '0;
        bus.p_req    = 1'b0;
        bus.p_arg    = '0;
        bus.eng_done = 1'b0;
        bus.eng_res  = '0;
        bus.clr_err  = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        PRESETn = 1'b0;
        step();
        step();
        PRESETn = 1'b1;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            bus.h_req    = 1'($urandom);
            bus.h_arg    = DW'($urandom);
            bus.p_req    = 1'($urandom);
            bus.p_arg    = DW'($urandom);
            bus.eng_done = 1'($urandom);
            bus.eng_res  = DW'($urandom);
            bus.clr_err  = 1'($urandom);
            step();
            total++;
            if ({bus.h_ack, bus.h_done, bus.p_ack, bus.p_done, bus.eng_start,
                 bus.owner, bus.timeout_err} !== 7'b0) begin
                bad++;
                $display("FAIL reset_flags cycle %0d: got %b want 0000000", i,
                         {bus.h_ack, bus.h_done, bus.p_ack, bus.p_done,
                          bus.eng_start, bus.owner, bus.timeout_err});
            end
            total++;
            if (bus.res !== 12'h000 || bus.eng_arg !== 12'h000) begin
                bad++;
                $display("FAIL reset_data: res=%h eng_arg=%h want 000/000",
                         bus.res, bus.eng_arg);
            end
        end
        clear_inputs();
        PRESETn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (bus.eng_start !== 1'b0 || bus.h_ack !== 1'b0 || bus.p_ack !== 1'b0) begin
                bad++;
                $display("FAIL idle_no_start cycle %0d: eng_start=%b h_ack=%b p_ack=%b want 0",
                         i, bus.eng_start, bus.h_ack, bus.p_ack);
            end
        end
    endtask

    task automatic test_single_host();
        apply_reset();
        // cycle 0
        bus.h_req = 1'b1;
        bus.h_arg = 12'h123;
        step(); // cycle 1
        total++;
        if (bus.h_ack !== 1'b1 || bus.eng_start !== 1'b1 || bus.p_ack !== 1'b0) begin
            bad++;
            $display("FAIL host_ack: h_ack=%b eng_start=%b p_ack=%b want 1 1 0",
                     bus.h_ack, bus.eng_start, bus.p_ack);
        end
        total++;
        if (bus.eng_arg !== 12'h123 || bus.owner !== 1'b0) begin
            bad++;
            $display("FAIL host_arg: eng_arg=%h owner=%b want 123 0", bus.eng_arg, bus.owner);
        end
        bus.h_req = 1'b0;
        step(); // cycle 2
        total++;
        if (bus.h_ack !== 1'b0 || bus.eng_start !== 1'b0) begin
            bad++;
            $display("FAIL host_ack_pulse: h_ack=%b eng_start=%b want 0 0",
                     bus.h_ack, bus.eng_start);
        end
        step(); // cycle 3
        step(); // cycle 4
        total++;
        if (bus.h_done !== 1'b0) begin
            bad++;
            $display("FAIL host_done_early: h_done=%b want 0", bus.h_done);
        end
        bus.eng_done = 1'b1;
        bus.eng_res  = 12'h456;
        step(); // cycle 5
        bus.eng_done = 1'b0;
        total++;
        if (bus.h_done !== 1'b1 || bus.res !== 12'h456 || bus.p_done !== 1'b0) begin
            bad++;
            $display("FAIL host_done: h_done=%b res=%h p_done=%b want 1 456 0",
                     bus.h_done, bus.res, bus.p_done);
        end
        step(); // cycle 6
        total++;
        if (bus.h_done !== 1'b0 || bus.res !== 12'h456) begin
            bad++;
            $display("FAIL host_done_pulse: h_done=%b res=%h want 0 456", bus.h_done, bus.res);
        end
    endtask

    task automatic test_fairness();
        apply_reset();
        // cycle 0: both request
        bus.h_req = 1'b1;
        bus.h_arg = 12'h0AA;
        bus.p_req = 1'b1;
        bus.p_arg = 12'h055;
        step(); // cycle 1
        total++;
        if (bus.h_ack !== 1'b1 || bus.p_ack !== 1'b0 || bus.eng_arg !== 12'h0AA || bus.owner !== 1'b0) begin
            bad++;
            $display("FAIL fair_first: h_ack=%b p_ack=%b eng_arg=%h owner=%b want 1 0 0aa 0",
                     bus.h_ack, bus.p_ack, bus.eng_arg, bus.owner);
        end
        bus.h_req = 1'b0;
        step(); // cycle 2: first WAIT
        bus.eng_done = 1'b1;
        bus.eng_res  = 12'h111;
        step(); // cycle 3
        bus.eng_done = 1'b0;
        total++;
        if (bus.h_done !== 1'b1 || bus.res !== 12'h111) begin
            bad++;
            $display("FAIL fair_first_done: h_done=%b res=%h want 1 111", bus.h_done, bus.res);
        end
        step(); // cycle 4: IDLE
        step(); // cycle 5
        total++;
        if (bus.p_ack !== 1'b1 || bus.h_ack !== 1'b0 || bus.eng_arg !== 12'h055 || bus.owner !== 1'b1) begin
            bad++;
            $display("FAIL fair_second: p_ack=%b h_ack=%b eng_arg=%h owner=%b want 1 0 055 1",
                     bus.p_ack, bus.h_ack, bus.eng_arg, bus.owner);
        end
        bus.p_req = 1'b0;
        step(); // cycle 6
        bus.eng_done = 1'b1;
        bus.eng_res  = 12'h222;
        step(); // cycle 7
        bus.eng_done = 1'b0;
        total++;
        if (bus.p_done !== 1'b1 || bus.h_done !== 1'b0 || bus.res !== 12'h222) begin
            bad++;
            $display("FAIL fair_second_done: p_done=%b h_done=%b res=%h want 1 0 222",
                     bus.p_done, bus.h_done, bus.res);
        end
        step(); // cycle 8: IDLE, third tie
        bus.h_req = 1'b1;
        bus.h_arg = 12'h0F0;
        bus.p_req = 1'b1;
        bus.p_arg = 12'h00F;
        step(); // cycle 9
        total++;
        if (bus.h_ack !== 1'b1 || bus.p_ack !== 1'b0 || bus.eng_arg !== 12'h0F0 || bus.owner !== 1'b0) begin
            bad++;
            $display("FAIL fair_third: h_ack=%b p_ack=%b eng_arg=%h owner=%b want 1 0 0f0 0",
                     bus.h_ack, bus.p_ack, bus.eng_arg, bus.owner);
        end
        bus.h_req = 1'b0; // p_req stays high, still pending
        step(); // cycle 10
        bus.eng_done = 1'b1;
        bus.eng_res  = 12'h333;
        step(); // cycle 11
        bus.eng_done = 1'b0;
        step(); // cycle 12: IDLE
        step(); // cycle 13
        total++;
        if (bus.p_ack !== 1'b1 || bus.eng_arg !== 12'h00F || bus.res !== 12'h333) begin
            bad++;
            $display("FAIL fair_pending_pid: p_ack=%b eng_arg=%h res=%h want 1 00f 333",
                     bus.p_ack, bus.eng_arg, bus.res);
        end
        bus.p_req = 1'b0;
        step(); // cycle 14
        bus.eng_done = 1'b1;
        bus.eng_res  = 12'h444;
        step(); // cycle 15
        bus.eng_done = 1'b0;
        total++;
        if (bus.p_done !== 1'b1 || bus.res !== 12'h444) begin
            bad++;
            $display("FAIL fair_pending_done: p_done=%b res=%h want 1 444", bus.p_done, bus.res);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        // preload res with a nonzero value via a short host transaction
        bus.h_req = 1'b1;
        bus.h_arg = 12'h001;
        step(); // cycle 1
        bus.h_req = 1'b0;
        step(); // cycle 2
        bus.eng_done = 1'b1;
        bus.eng_res  = 12'h5A5;
        step(); // cycle 3
        bus.eng_done = 1'b0;
        step(); // cycle 4: IDLE
        bus.p_req = 1'b1;
        bus.p_arg = 12'h3C3;
        step(); // cycle 5
        total++;
        if (bus.p_ack !== 1'b1 || bus.res !== 12'h5A5) begin
            bad++;
            $display("FAIL to_pid_ack: p_ack=%b res=%h want 1 5a5", bus.p_ack, bus.res);
        end
        bus.p_req = 1'b0;
        repeat (64) step(); // cycle 69: 64th WAIT cycle
        total++;
        if (bus.p_done !== 1'b0 || bus.timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL to_early: p_done=%b timeout_err=%b want 0 0", bus.p_done, bus.timeout_err);
        end
        step(); // cycle 70
        total++;
        if (bus.p_done !== 1'b1 || bus.res !== 12'h000 || bus.timeout_err !== 1'b1 || bus.h_done !== 1'b0) begin
            bad++;
            $display("FAIL to_abort: p_done=%b res=%h timeout_err=%b h_done=%b want 1 000 1 0",
                     bus.p_done, bus.res, bus.timeout_err, bus.h_done);
        end
        step(); // cycle 71
        total++;
        if (bus.timeout_err !== 1'b1 || bus.p_done !== 1'b0) begin
            bad++;
            $display("FAIL to_sticky: timeout_err=%b p_done=%b want 1 0", bus.timeout_err, bus.p_done);
        end
        bus.clr_err = 1'b1;
        step(); // cycle 72
        bus.clr_err = 1'b0;
        total++;
        if (bus.timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL to_clear: timeout_err=%b want 0", bus.timeout_err);
        end
        bus.h_req = 1'b1;
        bus.h_arg = 12'h777;
        step(); // cycle 73
        total++;
        if (bus.h_ack !== 1'b1) begin
            bad++;
            $display("FAIL to_second_ack: h_ack=%b want 1", bus.h_ack);
        end
        bus.h_req = 1'b0;
        repeat (64) step(); // cycle 137: terminal WAIT cycle
        bus.clr_err = 1'b1;
        step(); // cycle 138
        bus.clr_err = 1'b0;
        total++;
        if (bus.timeout_err !== 1'b1 || bus.h_done !== 1'b1) begin
            bad++;
            $display("FAIL to_set_over_clr: timeout_err=%b h_done=%b want 1 1",
                     bus.timeout_err, bus.h_done);
        end
        step(); // cycle 139
        total++;
        if (bus.timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL to_set_hold: timeout_err=%b want 1", bus.timeout_err);
        end
    endtask

    task automatic test_done_at_terminal();
        apply_reset();
        bus.p_req = 1'b1;
        bus.p_arg = 12'h7E7;
        step(); // cycle 1
        total++;
        if (bus.p_ack !== 1'b1 || bus.owner !== 1'b1 || bus.eng_arg !== 12'h7E7) begin
            bad++;
            $display("FAIL term_ack: p_ack=%b owner=%b eng_arg=%h want 1 1 7e7",
                     bus.p_ack, bus.owner, bus.eng_arg);
        end
        bus.p_req = 1'b0;
        repeat (64) step(); // cycle 65: terminal WAIT cycle
        bus.eng_done = 1'b1;
        bus.eng_res  = 12'hFFF;
        step(); // cycle 66
        bus.eng_done = 1'b0;
        total++;
        if (bus.p_done !== 1'b1 || bus.res !== 12'hFFF || bus.timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL term_done_wins: p_done=%b res=%h timeout_err=%b want 1 fff 0",
                     bus.p_done, bus.res, bus.timeout_err);
        end
        step(); // cycle 67
        total++;
        if (bus.p_done !== 1'b0 || bus.timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL term_after: p_done=%b timeout_err=%b want 0 0", bus.p_done, bus.timeout_err);
        end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        bus.h_req = 1'b1;
        bus.h_arg = 12'h246;
        step(); // cycle 1
        bus.h_req = 1'b0;
        step(); // cycle 2
        step(); // cycle 3: WAIT
        PRESETn = 1'b0;
        #1;
        total++;
        if ({bus.h_ack, bus.h_done, bus.p_ack, bus.p_done, bus.eng_start, bus.owner,
             bus.timeout_err} !== 7'b0 || bus.eng_arg !== 12'h000 || bus.res !== 12'h000) begin
            bad++;
            $display("FAIL midreset_clear: flags=%b eng_arg=%h res=%h want 0000000 000 000",
                     {bus.h_ack, bus.h_done, bus.p_ack, bus.p_done, bus.eng_start,
                      bus.owner, bus.timeout_err}, bus.eng_arg, bus.res);
        end
        step();
        step();
        PRESETn = 1'b1;
        step(); // 1 cycle after release
        step(); // 2 cycles after release: stray completion
        bus.eng_done = 1'b1;
        bus.eng_res  = 12'hABC;
        for (int i = 0; i < 4; i++) begin
            step();
            bus.eng_done = 1'b0;
            total++;
            if (bus.h_done !== 1'b0 || bus.p_done !== 1'b0 || bus.res !== 12'h000 || bus.eng_start !== 1'b0) begin
                bad++;
                $display("FAIL stray_done cycle %0d: h_done=%b p_done=%b res=%h eng_start=%b want 0 0 000 0",
                         i, bus.h_done, bus.p_done, bus.res, bus.eng_start);
            end
        end
        bus.h_req = 1'b1;
        bus.h_arg = 12'h321;
        step(); // cycle 1
        total++;
        if (bus.h_ack !== 1'b1 || bus.eng_arg !== 12'h321) begin
            bad++;
            $display("FAIL post_reset_ack: h_ack=%b eng_arg=%h want 1 321", bus.h_ack, bus.eng_arg);
        end
        bus.h_req = 1'b0;
        step(); // cycle 2
        bus.eng_done = 1'b1;
        bus.eng_res  = 12'h654;
        step(); // cycle 3
        bus.eng_done = 1'b0;
        total++;
        if (bus.h_done !== 1'b1 || bus.res !== 12'h654) begin
            bad++;
            $display("FAIL post_reset_done: h_done=%b res=%h want 1 654", bus.h_done, bus.res);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_inputs();
        PRESETn = 1'b0;
        test_reset();
        test_single_host();
        test_fairness();
        test_timeout();
        test_done_at_terminal();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
